alu_mdu_seq: RTL and testbench
==============================

// Module: alu_mdu_seq
// PURPOSE
//  Sequential execute unit for the RV32 core: base integer ops plus RV32M multiply/divide, with valid/ready handshakes.
//  Base ops complete in 1 cycle; MUL*/DIV*/REM* run iteratively (shift-add / restoring divide) over WIDTH cycles.
//  Sits between the decode/issue stage and writeback. Holds a result until writeback accepts it. Carries a tag for ordering.
// PARAMETERS
//  WIDTH    32  operand/result width in bits; a power of 2, >=8
//  TAG_W    5   width of the opaque tag (typically the rd index) passed from input to output
//  SHAMT_W  $clog2(WIDTH)  shift-amount bits used; derived, do not override
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       synchronous abort of any in-flight or held op
//  in_valid   in   1       op/operands valid
//  in_ready   out  1       unit can accept an op this cycle
//  alu_type   in   alu_type_t  operation (lib_pkg)
//  in0        in   WIDTH   operand rs1
//  in1        in   WIDTH   operand rs2/imm
//  in_tag     in   TAG_W   tag captured with the op
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out        out  WIDTH   result
//  out_tag    out  TAG_W   tag of result
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; out_valid=0, out=0, out_tag=0, busy=0; iteration counter=0.
//  Handshake: accept when in_valid&&in_ready. Result transfer when out_valid&&out_ready.
//   in_ready = (state==IDLE) || (state==DONE && out_ready): back-to-back issue allowed. in_ready=0 during flush.
//   out, out_tag and out_valid are stable while out_valid && !out_ready.
//  FSM: IDLE -> DONE on accept of a base op (latency 1: out_valid is set on the next edge).
//       IDLE -> MUL on MUL/MULH/MULHSU/MULHU; IDLE -> DIV on DIV/DIVU/REM/REMU.
//       MUL/DIV: the counter counts WIDTH iterations, then -> DONE. Latency WIDTH+1 cycles from accept to out_valid.
//       DONE -> IDLE on out_ready without a new accept; DONE -> DONE/MUL/DIV on out_ready with a new accept.
//  Base ops: ADD, SUB, XOR, OR, AND are modulo 2^WIDTH. Shifts use in1[SHAMT_W-1:0].
//   SRA is arithmetic. SLT is signed, SLTU unsigned; both return 0 or 1, zero-extended.
//  Multiply: operands are converted to magnitudes per signedness, a 2*WIDTH unsigned product is formed, then sign-fixed.
//   MUL gives the low WIDTH bits. MULH is s*s, MULHSU is s*u, MULHU is u*u; each gives the high WIDTH bits.
//  Divide: restoring divide on magnitudes; the quotient takes the sign of in0^in1 and the remainder the sign of in0.
//   Divide by zero: quotient = all-ones, remainder = in0. Detected at accept; still takes full latency.
//   Signed overflow (in0=-2^(WIDTH-1), in1=-1): DIV gives in0, REM gives 0.
//  flush: takes priority over all other inputs. Next edge: state=IDLE, out_valid=0; the op is discarded, not retried.
//  Reset mid-operation: immediate abort, all state is cleared, no partial result is ever shown.
//  Unknown alu_type: treated as base op, result 0 (never X).
// STRUCTURE
//  lib_pkg: extend alu_type_t with MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
//   Add to lib_pkg: the state enum mdu_state_t {IDLE, MUL, DIV, DONE} and the helper functions is_mul() and is_div().
//  Sub-module alu_mdu_div_iter holds the restoring-divide datapath: remainder reg, quotient reg, and step/load/done signals.
//   The multiplier shift-add loop and the base ops stay in the top.
// TESTING (WIDTH=32)
//  Reset mid-MUL: assert rst_n=0 at iteration 10 -> out_valid=0 at once; after release in_ready=1, busy=0.
//  Base ops back-to-back with out_ready=1: SUB 5-7 -> 0xFFFFFFFE; SRA 0x80000000>>>33 -> 0xC0000000; SLT -1<1 -> 1.
//   One result per cycle, in order, with matching tags.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. out_valid exactly 33 cycles after accept.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7. DIV -7/2 -> -3; REM -7/2 -> -1.
//  Backpressure: hold out_ready=0 for 5 cycles after DONE -> out/out_tag stable, in_ready=0. Release -> transfer plus a same-cycle new accept.
//  flush at iteration 20 of DIVU -> out_valid never rises for that tag; the next op's result and tag are correct.

Source files
------------

// File: rtl/lib_pkg.sv
// Shared types for the execute stage: operation encoding, MDU state encoding,
// and helpers that classify an operation as multiply or divide.
package lib_pkg;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_type_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } mdu_state_t;

    function automatic logic is_mul(alu_type_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div(alu_type_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/alu_mdu_div_iter.sv
// Restoring-divide datapath on unsigned magnitudes. One quotient bit per step;
// after WIDTH steps the quotient and remainder registers hold the result.
// The *_nxt outputs are the values after the current step, so the caller can
// capture the final result on the same edge as the last step.
module alu_mdu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             last_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_nxt_o,
    output logic [WIDTH-1:0] rem_nxt_o,
    output logic             done_o
);

    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH:0]   shifted, diff;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dsr_q};
        rem_d   = shifted[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Load operands on accept, advance one bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, so nothing stale or X can reach the result after reset.
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dsr_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quo_nxt_o = quo_d;
    assign rem_nxt_o = rem_d;
    assign done_o    = step_i & last_i;

endmodule

// File: rtl/alu_mdu_seq.sv
// Sequential execute unit: single-cycle base integer ops plus iterative
// RV32M multiply (shift-add) and divide (restoring), with valid/ready
// handshakes on both sides and a tag carried alongside each op.
module alu_mdu_seq
    import lib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_type_t        alu_type,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int                 SHAMT_W   = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

    mdu_state_t         state_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   out_q;
    logic [TAG_W-1:0]   tag_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               mul_hi_q;
    logic               res_neg_q;
    logic               div_rem_q;
    logic               div0_q;

    logic               accept;
    logic               a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               res_neg_d, mul_hi_d, div_rem_d;
    logic [WIDTH-1:0]   base_res;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_d, prod_fix;
    logic [WIDTH-1:0]   mul_res, div_res;
    logic [WIDTH-1:0]   quo_nxt, rem_nxt;
    logic               div_step, div_last, div_done;

    assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign out_tag   = tag_q;

    // Operand magnitudes and result-sign bookkeeping for multiply/divide
    always_comb begin
        a_signed  = alu_type inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
        b_signed  = alu_type inside {ALU_MULH, ALU_DIV, ALU_REM};
        a_neg     = a_signed & in0[WIDTH-1];
        b_neg     = b_signed & in1[WIDTH-1];
        a_mag     = a_neg ? -in0 : in0;
        b_mag     = b_neg ? -in1 : in1;
        div_rem_d = alu_type inside {ALU_REM, ALU_REMU};
        mul_hi_d  = alu_type inside {ALU_MULH, ALU_MULHSU, ALU_MULHU};
        res_neg_d = div_rem_d ? a_neg : (a_neg ^ b_neg);
    end

    // Single-cycle base operations; unknown encodings yield zero
    always_comb begin
        shamt = in1[SHAMT_W-1:0];
        case (alu_type)
            ALU_ADD:  base_res = in0 + in1;
            ALU_SUB:  base_res = in0 - in1;
            ALU_SLL:  base_res = in0 << shamt;
            ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
            ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, (in0 < in1)};
            ALU_XOR:  base_res = in0 ^ in1;
            ALU_SRL:  base_res = in0 >> shamt;
            ALU_SRA:  base_res = WIDTH'($signed(in0) >>> shamt);
            ALU_OR:   base_res = in0 | in1;
            ALU_AND:  base_res = in0 & in1;
            default:  base_res = '0;
        endcase
    end

    // Shift-add multiply step: prod_q holds {partial high, remaining multiplier}
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d   = {mul_sum, prod_q[WIDTH-1:1]};
        prod_fix = res_neg_q ? -prod_d : prod_d;
        mul_res  = mul_hi_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
    end

    // Sign fix of the divider result; divide-by-zero forces an all-ones quotient.
    // Signed overflow needs no special case: |min|/1 on magnitudes already yields min, rem 0.
    always_comb begin
        if (div_rem_q) begin
            div_res = res_neg_q ? -rem_nxt : rem_nxt;
        end else if (div0_q) begin
            div_res = '1;
        end else begin
            div_res = res_neg_q ? -quo_nxt : quo_nxt;
        end
    end

    assign div_step = (state_q == DIV);
    assign div_last = (cnt_q == LAST_ITER);

    alu_mdu_div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept && is_div(alu_type)),
        .step_i     (div_step),
        .last_i     (div_last),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quo_nxt_o  (quo_nxt),
        .rem_nxt_o  (rem_nxt),
        .done_o     (div_done)
    );

    // Control FSM with registered result, tag and multiply datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_q     <= '0;
            tag_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mul_hi_q  <= 1'b0;
            res_neg_q <= 1'b0;
            div_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (accept) begin
            tag_q     <= in_tag;
            cnt_q     <= '0;
            res_neg_q <= res_neg_d;
            mul_hi_q  <= mul_hi_d;
            div_rem_q <= div_rem_d;
            div0_q    <= (in1 == '0);
            if (is_mul(alu_type)) begin
                state_q <= MUL;
                prod_q  <= {{WIDTH{1'b0}}, b_mag};
                mcand_q <= a_mag;
            end else if (is_div(alu_type)) begin
                state_q <= DIV;
            end else begin
                state_q <= DONE;
                out_q   <= base_res;
            end
        end else begin
            case (state_q)
                MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + SHAMT_W'(1);
                    if (div_last) begin
                        state_q <= DONE;
                        out_q   <= mul_res;
                        cnt_q   <= '0;
                    end
                end
                DIV: begin
                    cnt_q <= cnt_q + SHAMT_W'(1);
                    if (div_done) begin
                        state_q <= DONE;
                        out_q   <= div_res;
                        cnt_q   <= '0;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed, table-driven bench for alu_mdu_seq (WIDTH=32) plus hand-written
// sequences for back-to-back issue, backpressure, flush and reset mid-op.
module tb_alu_mdu_seq;
    import lib_pkg::*;

    localparam int W = 32;
    localparam int T = 5;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    alu_type_t    alu_type;
    logic [W-1:0] in0, in1, out;
    logic [T-1:0] in_tag, out_tag;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        alu_type_t    op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [T-1:0] tag;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    alu_mdu_seq #(.WIDTH(W), .TAG_W(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_type  (alu_type),
        .in0       (in0),
        .in1       (in1),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(alu_type_t op, logic [W-1:0] a, logic [W-1:0] b,
                                logic [T-1:0] tag, logic [W-1:0] exp, int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.tag = tag; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    // Present one op for one edge; caller guarantees the unit is ready.
    task automatic issue(input alu_type_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [T-1:0] tag);
        in_valid = 1'b1; alu_type = op; in0 = a; in1 = b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counted so that a base op's result, visible just after the accept edge, is 1.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        issue(v.op, v.a, v.b, v.tag);
        wait_result(lat);
        check({name, " latency"}, W'(lat), W'(v.lat));
        check({name, " out"}, out, v.exp);
        check({name, " tag"}, W'(out_tag), W'(v.tag));
        @(posedge clk); #1;
    endtask

    initial begin
        int  lat;
        logic seen;
        logic [W-1:0] held_out;
        logic [T-1:0] held_tag;

        // op, a, b, tag, expected, latency
        vecs.push_back(mk(ALU_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 5'd1,  32'h8000_0000, 1));
        vecs.push_back(mk(ALU_ADD,    32'hFFFF_FFFF, 32'h0000_0002, 5'd2,  32'h0000_0001, 1));
        vecs.push_back(mk(ALU_SUB,    32'd5,         32'd7,         5'd3,  32'hFFFF_FFFE, 1));
        vecs.push_back(mk(ALU_SLL,    32'h0000_0001, 32'd35,        5'd4,  32'h0000_0008, 1));
        vecs.push_back(mk(ALU_SLT,    32'hFFFF_FFFF, 32'd1,         5'd5,  32'h0000_0001, 1));
        vecs.push_back(mk(ALU_SLTU,   32'hFFFF_FFFF, 32'd1,         5'd6,  32'h0000_0000, 1));
        vecs.push_back(mk(ALU_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7,  32'h0FF0_0FF0, 1));
        vecs.push_back(mk(ALU_OR,     32'hF0F0_F0F0, 32'h0F0F_0000, 5'd8,  32'hFFFF_F0F0, 1));
        vecs.push_back(mk(ALU_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9,  32'hF000_F000, 1));
        vecs.push_back(mk(ALU_SRL,    32'h8000_0000, 32'd33,        5'd10, 32'h4000_0000, 1));
        vecs.push_back(mk(ALU_SRA,    32'h8000_0000, 32'd33,        5'd11, 32'hC000_0000, 1));
        vecs.push_back(mk(alu_type_t'(5'd31), 32'h1234_5678, 32'h1, 5'd12, 32'h0000_0000, 1));
        vecs.push_back(mk(ALU_MUL,    32'h0001_0000, 32'h0001_0001, 5'd13, 32'h0001_0000, 33));
        vecs.push_back(mk(ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'h0000_0001, 33));
        vecs.push_back(mk(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 5'd15, 32'h4000_0000, 33));
        vecs.push_back(mk(ALU_MULH,   32'hFFFF_FFFF, 32'h0000_0001, 5'd16, 32'hFFFF_FFFF, 33));
        vecs.push_back(mk(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFF, 33));
        vecs.push_back(mk(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFE, 33));
        vecs.push_back(mk(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 33));
        vecs.push_back(mk(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0000_0000, 33));
        vecs.push_back(mk(ALU_DIVU,   32'd7,         32'd0,         5'd21, 32'hFFFF_FFFF, 33));
        vecs.push_back(mk(ALU_REMU,   32'd7,         32'd0,         5'd22, 32'h0000_0007, 33));
        vecs.push_back(mk(ALU_DIV,    32'hFFFF_FFF9, 32'd2,         5'd23, 32'hFFFF_FFFD, 33));
        vecs.push_back(mk(ALU_REM,    32'hFFFF_FFF9, 32'd2,         5'd24, 32'hFFFF_FFFF, 33));
        vecs.push_back(mk(ALU_DIVU,   32'd100,       32'd7,         5'd25, 32'h0000_000E, 33));
        vecs.push_back(mk(ALU_REMU,   32'd100,       32'd7,         5'd26, 32'h0000_0002, 33));
        vecs.push_back(mk(ALU_DIV,    32'hFFFF_FFF9, 32'd0,         5'd27, 32'hFFFF_FFFF, 33));
        vecs.push_back(mk(ALU_REM,    32'hFFFF_FFF9, 32'd0,         5'd28, 32'hFFFF_FFF9, 33));

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_type = ALU_ADD; in0 = '0; in1 = '0; in_tag = '0;
        #12;
        check("reset out_valid", W'(out_valid), 0);
        check("reset out",       out,           0);
        check("reset out_tag",   W'(out_tag),   0);
        check("reset busy",      W'(busy),      0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle in_ready", W'(in_ready), 1);

        // Table of single ops, each run to completion
        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back base ops: one result per cycle, in order
        in_valid = 1'b1; alu_type = ALU_SUB; in0 = 32'd5; in1 = 32'd7; in_tag = 5'd1;
        @(posedge clk); #1;
        check("b2b sub out", out, 32'hFFFF_FFFE);
        check("b2b sub tag", W'(out_tag), 1);
        check("b2b in_ready", W'(in_ready), 1);
        alu_type = ALU_SRA; in0 = 32'h8000_0000; in1 = 32'd33; in_tag = 5'd2;
        @(posedge clk); #1;
        check("b2b sra valid", W'(out_valid), 1);
        check("b2b sra out", out, 32'hC000_0000);
        check("b2b sra tag", W'(out_tag), 2);
        alu_type = ALU_SLT; in0 = 32'hFFFF_FFFF; in1 = 32'd1; in_tag = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b slt out", out, 32'h0000_0001);
        check("b2b slt tag", W'(out_tag), 3);
        @(posedge clk); #1;
        check("b2b drained", W'(out_valid), 0);

        // Backpressure: result held stable, then transfer with same-cycle accept
        out_ready = 1'b0;
        issue(ALU_MUL, 32'd6, 32'd7, 5'd9);
        wait_result(lat);
        check("bp latency", W'(lat), 33);
        check("bp out", out, 32'd42);
        held_out = out; held_tag = out_tag;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d valid", k), W'(out_valid), 1);
            check($sformatf("bp hold%0d out", k), out, held_out);
            check($sformatf("bp hold%0d tag", k), W'(out_tag), W'(held_tag));
            check($sformatf("bp hold%0d in_ready", k), W'(in_ready), 0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; alu_type = ALU_ADD; in0 = 32'd3; in1 = 32'd4; in_tag = 5'd10;
        #1;
        check("bp release in_ready", W'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp new valid", W'(out_valid), 1);
        check("bp new out", out, 32'd7);
        check("bp new tag", W'(out_tag), 10);
        @(posedge clk); #1;

        // Flush at iteration 20 of a DIVU: its result must never appear
        issue(ALU_DIVU, 32'd100, 32'd7, 5'd7);
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush in_ready", W'(in_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush out_valid", W'(out_valid), 0);
        check("flush busy", W'(busy), 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush no result", W'(seen), 0);
        flush = 1'b1;
        #1;
        check("flush idle in_ready", W'(in_ready), 0);
        flush = 1'b0;
        #1;
        run_vec("post-flush div", mk(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD, 33));

        // Reset at iteration 10 of a MUL: immediate abort, no result afterwards
        issue(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13);
        repeat (10) @(posedge clk);
        #1;
        check("mid-mul busy", W'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst mid-mul out_valid", W'(out_valid), 0);
        check("rst mid-mul busy", W'(busy), 0);
        check("rst mid-mul out", out, 0);
        #5;
        rst_n = 1'b1;
        #1;
        check("rst release in_ready", W'(in_ready), 1);
        check("rst release busy", W'(busy), 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst no result", W'(seen), 0);
        run_vec("post-reset mulh", mk(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 5'd14, 32'h4000_0000, 33));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
